axi_mem_master: RTL and testbench
=================================

# axi_mem_master

AXI4 master that turns a simple valid/ready native memory port (RISC-V core instruction/data port) into single-beat AXI4 read and write transactions. It sits between a core's memory interface and the AXI interconnect feeding the BRAM controllers. It keeps one transaction outstanding, registers all AXI outputs, and reports slave error responses back to the core.

## Interface
- BYTES_PER_WORD, 4, data bytes per beat (power of two)
- ADDRESS_WIDTH, 32, address width
- ID_WIDTH, 6, AXI ID width
- AXI_ID, 0, constant ID driven on M_AXI_arid/awid
- CLK  in  1  clock; all logic rising-edge
- RST  in  1  reset, asynchronous, active-high
- mem_valid  in  1  request valid; held with all request fields until mem_ready
- mem_instr  in  1  instruction fetch (sets prot[2])
- mem_addr  in  ADDRESS_WIDTH  byte address
- mem_wdata  in  BYTES_PER_WORD*8  write data
- mem_wstrb  in  BYTES_PER_WORD  byte enables; 0 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  BYTES_PER_WORD*8  read data, valid with mem_ready
- mem_error  out  1  resp != OKAY, valid with mem_ready
- M_AXI_ar{addr,len,size,burst,prot,cache,lock,qos,region,user,id,valid}  out  standard AXI4 widths; M_AXI_arready  in
- M_AXI_aw{addr,len,size,burst,prot,cache,lock,qos,region,user,id,valid}  out; M_AXI_awready  in
- M_AXI_w{data,strb,last,valid}  out; M_AXI_wready  in
- M_AXI_b{valid,id,resp,user}  in; M_AXI_bready  out
- M_AXI_r{valid,data,last,id,resp,user}  in; M_AXI_rready  out

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: mem_valid && wstrb==0 -> RD_ADDR; mem_valid && wstrb!=0 -> WR_REQ; request fields captured into registers on that edge.
- RD_ADDR: arvalid=1 until arready; then -> RD_DATA.
- RD_DATA: rready=1; on rvalid capture rdata, error = (rresp!=0) -> DONE.
- WR_REQ: awvalid and wvalid raised together; each drops independently on its own handshake; when both have completed (same or different cycles) -> WR_RESP.
- WR_RESP: bready=1; on bvalid error = (bresp!=0) -> DONE.
- DONE: mem_ready=1 for exactly one cycle -> IDLE. A new request is sampled only in IDLE, so a request held one cycle past mem_ready is not re-issued.
- Constants: len=0, size=log2(BYTES_PER_WORD), burst=INCR(01), cache=0011, lock/qos/region/user=0, wlast=1, prot={mem_instr,2'b00}.
- Address: mem_addr with low log2(BYTES_PER_WORD) bits forced to 0; wstrb passed unmodified.
- rid/bid/rlast not checked; responses with any ID are accepted.
- mem_rdata holds last read value until the next read completes; on writes it is unchanged.

## Timing
- Reset (asynchronous, immediate): state=IDLE; every output 0 (valids, readies, mem_ready, mem_error, mem_rdata, addresses, data).
- Reset mid-transaction abandons it; no AXI cleanup (interconnect shares reset).
- Read latency, zero-wait slave: request edge 0 -> arvalid from cycle 1 -> rready from cycle 2 -> rvalid sampled cycle 2 -> mem_ready cycle 3. Total 3 cycles plus slave wait states.
- Write latency, zero-wait slave: awvalid/wvalid cycle 1, bready cycle 2, bvalid sampled cycle 2 -> mem_ready cycle 3.
- valid signals never drop before their handshake; payload stable while valid high.
- Minimum spacing between accepted requests: 4 cycles (DONE -> IDLE -> issue).
- Simultaneous awready and wready in the first cycle: both complete; WR_RESP entered next cycle.

## Structure
- Package axi_master_pkg: state enum, AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE_DEFAULT, size computation function.
- Single module, no sub-module; channel valid registers and FSM in one always block, constant assigns separately.

## Test plan
- Read 0x0000_1006, slave returns 0xDEADBEEF with zero wait -> araddr=0x1004, arlen=0, arsize=2, mem_ready cycle 3 with rdata=0xDEADBEEF, error=0.
- Write 0x0000_0010 data 0x12345678 strb 0011, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3, single bready handshake, one mem_ready.
- Write with bresp=SLVERR (10) -> mem_ready with mem_error=1; next OKAY read -> mem_error=0.
- mem_instr=1 read -> arprot=100; data read -> arprot=000.
- mem_valid held high across 3 consecutive different requests -> exactly 3 AXI transactions, 3 mem_ready pulses, requests ≥4 cycles apart.
- RST asserted while in RD_DATA -> all outputs 0 same cycle; after release, fresh read completes normally.

Source files
------------

// File: rtl/axi_mem_master_pkg.sv
// Shared types and constants for axi_mem_master.
// Provides the FSM state enum, fixed AXI4 encodings, and the AxSIZE helper.
package axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0]  AXI_CACHE_DEFAULT = 4'b0011;
  localparam int unsigned AXI_USER_WIDTH    = 1;

  // AxSIZE encoding for a beat of 'bytes' bytes (bytes must be a power of two).
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_mem_master_if.sv
// Bundle of the native core memory port and the AXI4 master channels.
// modport master : the axi_mem_master side (drives AXI requests, mem_ready/rdata/error).
// modport slave  : the core + interconnect side (drives mem requests, AXI responses).
interface axi_mem_master_if #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned ID_WIDTH       = 6
);
  localparam int unsigned DW = BYTES_PER_WORD * 8;
  localparam int unsigned UW = axi_master_pkg::AXI_USER_WIDTH;

  // native memory port
  logic                      mem_valid;
  logic                      mem_instr;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic [BYTES_PER_WORD-1:0] mem_wstrb;
  logic                      mem_ready;
  logic [DW-1:0]             mem_rdata;
  logic                      mem_error;

  // read address
  logic [ADDRESS_WIDTH-1:0]  M_AXI_araddr;
  logic [7:0]                M_AXI_arlen;
  logic [2:0]                M_AXI_arsize;
  logic [1:0]                M_AXI_arburst;
  logic [2:0]                M_AXI_arprot;
  logic [3:0]                M_AXI_arcache;
  logic                      M_AXI_arlock;
  logic [3:0]                M_AXI_arqos;
  logic [3:0]                M_AXI_arregion;
  logic [UW-1:0]             M_AXI_aruser;
  logic [ID_WIDTH-1:0]       M_AXI_arid;
  logic                      M_AXI_arvalid;
  logic                      M_AXI_arready;

  // write address
  logic [ADDRESS_WIDTH-1:0]  M_AXI_awaddr;
  logic [7:0]                M_AXI_awlen;
  logic [2:0]                M_AXI_awsize;
  logic [1:0]                M_AXI_awburst;
  logic [2:0]                M_AXI_awprot;
  logic [3:0]                M_AXI_awcache;
  logic                      M_AXI_awlock;
  logic [3:0]                M_AXI_awqos;
  logic [3:0]                M_AXI_awregion;
  logic [UW-1:0]             M_AXI_awuser;
  logic [ID_WIDTH-1:0]       M_AXI_awid;
  logic                      M_AXI_awvalid;
  logic                      M_AXI_awready;

  // write data
  logic [DW-1:0]             M_AXI_wdata;
  logic [BYTES_PER_WORD-1:0] M_AXI_wstrb;
  logic                      M_AXI_wlast;
  logic                      M_AXI_wvalid;
  logic                      M_AXI_wready;

  // write response
  logic                      M_AXI_bvalid;
  logic [ID_WIDTH-1:0]       M_AXI_bid;
  logic [1:0]                M_AXI_bresp;
  logic [UW-1:0]             M_AXI_buser;
  logic                      M_AXI_bready;

  // read data
  logic                      M_AXI_rvalid;
  logic [DW-1:0]             M_AXI_rdata;
  logic                      M_AXI_rlast;
  logic [ID_WIDTH-1:0]       M_AXI_rid;
  logic [1:0]                M_AXI_rresp;
  logic [UW-1:0]             M_AXI_ruser;
  logic                      M_AXI_rready;

  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_error,
    output M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst, M_AXI_arprot,
           M_AXI_arcache, M_AXI_arlock, M_AXI_arqos, M_AXI_arregion, M_AXI_aruser,
           M_AXI_arid, M_AXI_arvalid,
    input  M_AXI_arready,
    output M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awprot,
           M_AXI_awcache, M_AXI_awlock, M_AXI_awqos, M_AXI_awregion, M_AXI_awuser,
           M_AXI_awid, M_AXI_awvalid,
    input  M_AXI_awready,
    output M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    input  M_AXI_wready,
    input  M_AXI_bvalid, M_AXI_bid, M_AXI_bresp, M_AXI_buser,
    output M_AXI_bready,
    input  M_AXI_rvalid, M_AXI_rdata, M_AXI_rlast, M_AXI_rid, M_AXI_rresp, M_AXI_ruser,
    output M_AXI_rready
  );

  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_error,
    input  M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst, M_AXI_arprot,
           M_AXI_arcache, M_AXI_arlock, M_AXI_arqos, M_AXI_arregion, M_AXI_aruser,
           M_AXI_arid, M_AXI_arvalid,
    output M_AXI_arready,
    input  M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awprot,
           M_AXI_awcache, M_AXI_awlock, M_AXI_awqos, M_AXI_awregion, M_AXI_awuser,
           M_AXI_awid, M_AXI_awvalid,
    output M_AXI_awready,
    input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    output M_AXI_wready,
    output M_AXI_bvalid, M_AXI_bid, M_AXI_bresp, M_AXI_buser,
    input  M_AXI_bready,
    output M_AXI_rvalid, M_AXI_rdata, M_AXI_rlast, M_AXI_rid, M_AXI_rresp, M_AXI_ruser,
    input  M_AXI_rready
  );

endinterface

// File: rtl/axi_mem_master.sv
// axi_mem_master: converts a valid/ready native memory port into single-beat
// AXI4 reads/writes, one transaction outstanding, all AXI outputs registered.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - axi_mem_master_if.master: native mem_* port plus M_AXI_* channels
module axi_mem_master
  import axi_master_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned ID_WIDTH       = 6,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                CLK,
  input  logic                RST,
  axi_mem_master_if.master    bus
);

  localparam int unsigned DW = BYTES_PER_WORD * 8;
  localparam logic [2:0]  BEAT_SIZE = axi_size(BYTES_PER_WORD);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~(ADDRESS_WIDTH'(BYTES_PER_WORD - 1));

  state_e                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [2:0]                prot_q, prot_d;
  logic [DW-1:0]             wdata_q, wdata_d;
  logic [BYTES_PER_WORD-1:0] wstrb_q, wstrb_d;
  logic                      arvalid_q, arvalid_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      rready_q, rready_d;
  logic                      bready_q, bready_d;
  logic                      mem_ready_q, mem_ready_d;
  logic                      mem_error_q, mem_error_d;
  logic [DW-1:0]             rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prot_d      = prot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    rready_d    = rready_q;
    bready_d    = bready_q;
    mem_ready_d = 1'b0;
    mem_error_d = mem_error_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          addr_d  = bus.mem_addr & ADDR_MASK;
          prot_d  = {bus.mem_instr, 2'b00};
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          if (bus.mem_wstrb == '0) begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end
        end
      end
      ST_RD_ADDR: begin
        if (bus.M_AXI_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (bus.M_AXI_rvalid) begin
          rready_d    = 1'b0;
          rdata_d     = bus.M_AXI_rdata;
          mem_error_d = (bus.M_AXI_rresp != AXI_RESP_OKAY);
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        // AW and W retire independently; leave once neither is still pending
        // after this edge, whether they finished together or apart.
        if (bus.M_AXI_awready) awvalid_d = 1'b0;
        if (bus.M_AXI_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bus.M_AXI_bvalid) begin
          bready_d    = 1'b0;
          mem_error_d = (bus.M_AXI_bresp != AXI_RESP_OKAY);
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // mem_ready is high this cycle; the core's request is ignored until IDLE
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_error_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
      mem_error_q <= mem_error_d;
      rdata_q     <= rdata_d;
    end
  end

  // Response IDs, rlast and user sidebands are intentionally ignored.
  logic unused_resp;
  assign unused_resp = ^{bus.M_AXI_rid, bus.M_AXI_rlast, bus.M_AXI_ruser,
                         bus.M_AXI_bid, bus.M_AXI_buser};

  assign bus.M_AXI_araddr   = addr_q;
  assign bus.M_AXI_arlen    = '0;
  assign bus.M_AXI_arsize   = BEAT_SIZE;
  assign bus.M_AXI_arburst  = AXI_BURST_INCR;
  assign bus.M_AXI_arprot   = prot_q;
  assign bus.M_AXI_arcache  = AXI_CACHE_DEFAULT;
  assign bus.M_AXI_arlock   = 1'b0;
  assign bus.M_AXI_arqos    = '0;
  assign bus.M_AXI_arregion = '0;
  assign bus.M_AXI_aruser   = '0;
  assign bus.M_AXI_arid     = ID_WIDTH'(AXI_ID);
  assign bus.M_AXI_arvalid  = arvalid_q;

  assign bus.M_AXI_awaddr   = addr_q;
  assign bus.M_AXI_awlen    = '0;
  assign bus.M_AXI_awsize   = BEAT_SIZE;
  assign bus.M_AXI_awburst  = AXI_BURST_INCR;
  assign bus.M_AXI_awprot   = prot_q;
  assign bus.M_AXI_awcache  = AXI_CACHE_DEFAULT;
  assign bus.M_AXI_awlock   = 1'b0;
  assign bus.M_AXI_awqos    = '0;
  assign bus.M_AXI_awregion = '0;
  assign bus.M_AXI_awuser   = '0;
  assign bus.M_AXI_awid     = ID_WIDTH'(AXI_ID);
  assign bus.M_AXI_awvalid  = awvalid_q;

  assign bus.M_AXI_wdata    = wdata_q;
  assign bus.M_AXI_wstrb    = wstrb_q;
  assign bus.M_AXI_wlast    = 1'b1;
  assign bus.M_AXI_wvalid   = wvalid_q;

  assign bus.M_AXI_bready   = bready_q;
  assign bus.M_AXI_rready   = rready_q;

  assign bus.mem_ready      = mem_ready_q;
  assign bus.mem_rdata      = rdata_q;
  assign bus.mem_error      = mem_error_q;

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed testbench for axi_mem_master with a configurable-latency AXI slave.
module tb_axi_mem_master;
  import axi_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mem_master_if #(.BYTES_PER_WORD(4), .ADDRESS_WIDTH(32), .ID_WIDTH(6)) bus ();

  axi_mem_master #(
    .BYTES_PER_WORD(4),
    .ADDRESS_WIDTH (32),
    .ID_WIDTH      (6),
    .AXI_ID        (0)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // slave configuration
  int unsigned ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
  logic [31:0] r_data = 32'h0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;

  // monitor counters / captures
  int unsigned cyc = 0;
  int unsigned n_ar = 0, n_aw = 0, n_w = 0, n_r = 0, n_b = 0, n_ready = 0;
  int unsigned aw_hi = 0, w_hi = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [2:0]  last_arprot = '0, last_awprot = '0;
  logic [3:0]  last_wstrb = '0;
  logic        last_wlast = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // AXI slave: updates 1 time unit after each rising edge
  initial begin : slave
    int unsigned ar_w, aw_w, w_w, r_w, b_w;
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs, r_pend, b_pend, aw_got, w_got;
    ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    bus.M_AXI_arready = 0; bus.M_AXI_awready = 0; bus.M_AXI_wready = 0;
    bus.M_AXI_rvalid = 0; bus.M_AXI_rdata = '0; bus.M_AXI_rresp = '0;
    bus.M_AXI_rlast = 1'b1; bus.M_AXI_rid = 6'h2A; bus.M_AXI_ruser = '0;
    bus.M_AXI_bvalid = 0; bus.M_AXI_bresp = '0; bus.M_AXI_bid = 6'h15; bus.M_AXI_buser = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        bus.M_AXI_arready = 0; bus.M_AXI_awready = 0; bus.M_AXI_wready = 0;
        bus.M_AXI_rvalid = 0; bus.M_AXI_bvalid = 0;
      end else begin
        if (ar_hs) begin n_ar++; r_pend = 1; r_w = 0; end
        if (aw_hs) begin n_aw++; aw_got = 1; end
        if (w_hs)  begin n_w++;  w_got = 1; end
        if (r_hs)  begin n_r++;  r_pend = 0; end
        if (b_hs)  begin n_b++;  b_pend = 0; end
        if (aw_got && w_got) begin b_pend = 1; b_w = 0; aw_got = 0; w_got = 0; end
        if (bus.mem_ready)     n_ready++;
        if (bus.M_AXI_awvalid) aw_hi++;
        if (bus.M_AXI_wvalid)  w_hi++;

        ar_hs = bus.M_AXI_arvalid && (ar_w >= ar_delay);
        if (bus.M_AXI_arvalid && !ar_hs) ar_w++; else ar_w = 0;
        if (ar_hs) begin last_araddr = bus.M_AXI_araddr; last_arprot = bus.M_AXI_arprot; end
        bus.M_AXI_arready = ar_hs;

        aw_hs = bus.M_AXI_awvalid && (aw_w >= aw_delay);
        if (bus.M_AXI_awvalid && !aw_hs) aw_w++; else aw_w = 0;
        if (aw_hs) begin last_awaddr = bus.M_AXI_awaddr; last_awprot = bus.M_AXI_awprot; end
        bus.M_AXI_awready = aw_hs;

        w_hs = bus.M_AXI_wvalid && (w_w >= w_delay);
        if (bus.M_AXI_wvalid && !w_hs) w_w++; else w_w = 0;
        if (w_hs) begin
          last_wdata = bus.M_AXI_wdata; last_wstrb = bus.M_AXI_wstrb; last_wlast = bus.M_AXI_wlast;
        end
        bus.M_AXI_wready = w_hs;

        r_hs = r_pend && (r_w >= r_delay);
        if (r_pend && !r_hs) r_w++;
        bus.M_AXI_rvalid = r_hs;
        bus.M_AXI_rdata  = r_hs ? r_data : '0;
        bus.M_AXI_rresp  = r_hs ? r_resp : '0;
        r_hs = r_hs && bus.M_AXI_rready;

        b_hs = b_pend && (b_w >= b_delay);
        if (b_pend && !b_hs) b_w++;
        bus.M_AXI_bvalid = b_hs;
        bus.M_AXI_bresp  = b_hs ? b_resp : '0;
        b_hs = b_hs && bus.M_AXI_bready;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one request, wait for mem_ready, hold it through the DONE edge, then drop.
  task automatic issue(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output int unsigned lat);
    bus.mem_instr = instr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    bus.mem_valid = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.mem_ready && lat < 40);
    check("mem_ready_timeout", bus.mem_ready, 1);
    step();
    bus.mem_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int unsigned lat;
    int unsigned s_ar, s_aw, s_b, s_ready, s_awhi, s_whi;
    int unsigned t [3];

    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0;   bus.mem_wstrb = '0;

    // reset state
    #3;
    check("rst_arvalid", bus.M_AXI_arvalid, 0);
    check("rst_awvalid", bus.M_AXI_awvalid, 0);
    check("rst_wvalid",  bus.M_AXI_wvalid, 0);
    check("rst_ready",   {bus.M_AXI_rready, bus.M_AXI_bready, bus.mem_ready, bus.mem_error}, 0);
    check("rst_rdata",   bus.mem_rdata, 0);
    step(); step();
    rst = 1'b0;
    step();

    // read 0x1006, zero-wait slave, cycle-by-cycle
    r_data = 32'hDEADBEEF;
    bus.mem_instr = 1'b0; bus.mem_addr = 32'h0000_1006; bus.mem_wstrb = 4'h0;
    bus.mem_valid = 1'b1;
    step();
    check("c1_arvalid", bus.M_AXI_arvalid, 1);
    check("c1_araddr",  bus.M_AXI_araddr, 32'h0000_1004);
    check("c1_arlen",   bus.M_AXI_arlen, 0);
    check("c1_arsize",  bus.M_AXI_arsize, 2);
    check("c1_arburst", bus.M_AXI_arburst, 1);
    check("c1_arcache", bus.M_AXI_arcache, 4'b0011);
    check("c1_arprot",  bus.M_AXI_arprot, 0);
    check("c1_rready",  bus.M_AXI_rready, 0);
    step();
    check("c2_arvalid", bus.M_AXI_arvalid, 0);
    check("c2_rready",  bus.M_AXI_rready, 1);
    step();
    check("c3_mem_ready", bus.mem_ready, 1);
    check("c3_rdata",     bus.mem_rdata, 32'hDEADBEEF);
    check("c3_error",     bus.mem_error, 0);
    step();
    check("c4_mem_ready", bus.mem_ready, 0);
    bus.mem_valid = 1'b0;
    step();
    check("c5_no_reissue", bus.M_AXI_arvalid, 0);
    check("c5_rdata_hold", bus.mem_rdata, 32'hDEADBEEF);

    // write with awready delayed, wready immediate
    aw_delay = 2;
    s_aw = n_aw; s_b = n_b; s_ready = n_ready; s_awhi = aw_hi; s_whi = w_hi;
    issue(1'b0, 32'h0000_0010, 32'h1234_5678, 4'b0011, lat);
    step();
    check("wr_latency",  lat, 5);
    check("wr_aw_cycles", aw_hi - s_awhi, 3);
    check("wr_w_cycles",  w_hi - s_whi, 1);
    check("wr_n_aw",     n_aw - s_aw, 1);
    check("wr_n_b",      n_b - s_b, 1);
    check("wr_n_ready",  n_ready - s_ready, 1);
    check("wr_awaddr",   last_awaddr, 32'h0000_0010);
    check("wr_wdata",    last_wdata, 32'h1234_5678);
    check("wr_wstrb",    last_wstrb, 4'b0011);
    check("wr_wlast",    last_wlast, 1);
    check("wr_error",    bus.mem_error, 0);
    check("wr_rdata_keep", bus.mem_rdata, 32'hDEADBEEF);
    aw_delay = 0;

    // SLVERR write, then OKAY read clears the error
    b_resp = 2'b10;
    issue(1'b0, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, lat);
    check("slverr_latency", lat, 3);
    check("slverr_error",   bus.mem_error, 1);
    b_resp = 2'b00;
    r_data = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0, lat);
    check("okay_rd_error", bus.mem_error, 0);
    check("okay_rd_rdata", bus.mem_rdata, 32'hCAFE_F00D);

    // instruction vs data fetch protection
    issue(1'b1, 32'h0000_3008, 32'h0, 4'h0, lat);
    check("instr_arprot", last_arprot, 3'b100);
    check("instr_araddr", last_araddr, 32'h0000_3008);
    issue(1'b0, 32'h0000_300C, 32'h0, 4'h0, lat);
    check("data_arprot",  last_arprot, 3'b000);

    // mem_valid held across three back-to-back requests
    s_ar = n_ar; s_aw = n_aw; s_b = n_b; s_ready = n_ready;
    bus.mem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.mem_instr = 1'b0;
      bus.mem_addr  = 32'h0000_0100 + 32'(k * 4);
      bus.mem_wdata = 32'h5555_0000 + 32'(k);
      bus.mem_wstrb = (k == 1) ? 4'hF : 4'h0;
      lat = 0;
      do begin
        step();
        lat++;
      end while (!bus.mem_ready && lat < 40);
      check("held_ready", bus.mem_ready, 1);
      t[k] = cyc;
    end
    step();
    bus.mem_valid = 1'b0;
    repeat (6) step();
    check("held_spacing01", t[1] - t[0], 4);
    check("held_spacing12", t[2] - t[1], 4);
    check("held_n_ar",    n_ar - s_ar, 2);
    check("held_n_aw",    n_aw - s_aw, 1);
    check("held_n_b",     n_b - s_b, 1);
    check("held_n_ready", n_ready - s_ready, 3);
    check("held_awaddr",  last_awaddr, 32'h0000_0104);

    // asynchronous reset while waiting in RD_DATA
    r_delay = 5;
    bus.mem_instr = 1'b0; bus.mem_addr = 32'h0000_0400; bus.mem_wstrb = 4'h0;
    bus.mem_valid = 1'b1;
    step(); step();
    check("pre_rst_rready", bus.M_AXI_rready, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_rready",  bus.M_AXI_rready, 0);
    check("arst_araddr",  bus.M_AXI_araddr, 0);
    check("arst_rdata",   bus.mem_rdata, 0);
    check("arst_others",  {bus.M_AXI_arvalid, bus.M_AXI_awvalid, bus.M_AXI_wvalid,
                           bus.M_AXI_bready, bus.mem_ready, bus.mem_error}, 0);
    bus.mem_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    r_delay = 0;
    r_data = 32'h0BAD_F00D;
    step();
    issue(1'b0, 32'h0000_0404, 32'h0, 4'h0, lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_rdata",   bus.mem_rdata, 32'h0BAD_F00D);
    check("post_rst_error",   bus.mem_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
